// File: rtl/step_motion_controller_if.sv
// Move-command handshake between the command decoder (master) and the stepper
// sequencer (slave).
interface step_motion_controller_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PER_W = 20
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/step_motion_controller.sv
// Half-step sequencer for a 4-phase unipolar stepper: runs counted, abortable
// moves and drives the coil pattern from registered state.
module step_motion_controller #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PER_W      = 20,
    parameter int unsigned MIN_PERIOD = 1000
) (
    input  logic                     saatDarbesi,
    input  logic                     rst,
    step_motion_controller_if.slave  cmd,
    input  logic                     abort,
    input  logic                     release_en,
    output logic [3:0]               motorCikis,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [2:0]               phase_idx
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [PER_W-1:0] MinPer = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] OnePer = PER_W'(1);
    localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

    logic [1:0]       stateQ, stateD;
    logic [2:0]       idxQ, idxD;
    logic [CNT_W-1:0] remainingQ, remainingD;
    logic [PER_W-1:0] timerQ, timerD;
    logic [PER_W-1:0] perQ, perD;
    logic             dirQ, dirD;
    logic             readyQ;
    logic             abortHit;
    logic [3:0]       coilD;

    function automatic logic [3:0] phaseTable(input logic [2:0] i);
        case (i)
            3'd0:    phaseTable = 4'b0001;
            3'd1:    phaseTable = 4'b0011;
            3'd2:    phaseTable = 4'b0010;
            3'd3:    phaseTable = 4'b0110;
            3'd4:    phaseTable = 4'b0100;
            3'd5:    phaseTable = 4'b1100;
            3'd6:    phaseTable = 4'b1000;
            default: phaseTable = 4'b1001;
        endcase
    endfunction

    always_comb begin
        stateD     = stateQ;
        idxD       = idxQ;
        remainingD = remainingQ;
        timerD     = timerQ;
        perD       = perQ;
        dirD       = dirQ;
        abortHit   = 1'b0;
        case (stateQ)
            StIdle: begin
                if (cmd.cmd_valid && readyQ) begin
                    dirD       = cmd.cmd_dir;
                    remainingD = cmd.cmd_steps;
                    perD       = (cmd.cmd_period < MinPer) ? MinPer : cmd.cmd_period;
                    timerD     = '0;
                    stateD     = (cmd.cmd_steps == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Abort wins over a step that would otherwise land on this edge.
                if (abort) begin
                    stateD   = StDone;
                    abortHit = 1'b1;
                end else if (timerQ == perQ - OnePer) begin
                    timerD = '0;
                    idxD   = dirQ ? idxQ + 3'd1 : idxQ - 3'd1;
                    if (remainingQ != '0) begin
                        remainingD = remainingQ - OneCnt;
                    end
                    if (remainingQ == OneCnt) begin
                        stateD = StDone;
                    end
                end else begin
                    timerD = timerQ + OnePer;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
        coilD = (stateD == StIdle && release_en) ? 4'b0000 : phaseTable(idxD);
    end

    always_ff @(posedge saatDarbesi or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            idxQ       <= '0;
            remainingQ <= '0;
            timerQ     <= '0;
            perQ       <= MinPer;
            dirQ       <= 1'b0;
            readyQ     <= 1'b0;
            motorCikis <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            stateQ     <= stateD;
            idxQ       <= idxD;
            remainingQ <= remainingD;
            timerQ     <= timerD;
            perQ       <= perD;
            dirQ       <= dirD;
            readyQ     <= (stateD == StIdle);
            motorCikis <= coilD;
            busy       <= (stateD == StRun);
            done       <= (stateD == StDone);
            aborted    <= abortHit;
        end
    end

    assign cmd.cmd_ready = readyQ;
    assign phase_idx     = idxQ;

endmodule

// File: tb/tb_step_motion_controller.sv
// Directed bench for step_motion_controller: one task per scenario, each with
// hand-computed expected phase indices and coil patterns.
module tb_step_motion_controller;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PER_W = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       release_en = 1'b0;
    logic [3:0] motorCikis;
    logic       busy, done, aborted;
    logic [2:0] phase_idx;

    int compared   = 0;
    int mismatched = 0;
    logic [2:0] expIdx;

    step_motion_controller_if #(.CNT_W(CNT_W), .PER_W(PER_W)) cmdIf ();

    step_motion_controller #(.CNT_W(CNT_W), .PER_W(PER_W), .MIN_PERIOD(1000)) dut (
        .saatDarbesi (clk),
        .rst         (rst),
        .cmd         (cmdIf.slave),
        .abort       (abort),
        .release_en  (release_en),
        .motorCikis  (motorCikis),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .phase_idx   (phase_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = 4'b0001;
            3'd1:    tbl = 4'b0011;
            3'd2:    tbl = 4'b0010;
            3'd3:    tbl = 4'b0110;
            3'd4:    tbl = 4'b0100;
            3'd5:    tbl = 4'b1100;
            3'd6:    tbl = 4'b1000;
            default: tbl = 4'b1001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one command for exactly one edge; returns just after the accept edge.
    task automatic accept(input logic dir, input int steps, input int period);
        cmdIf.cmd_dir    = dir;
        cmdIf.cmd_steps  = CNT_W'(steps);
        cmdIf.cmd_period = PER_W'(period);
        cmdIf.cmd_valid  = 1'b1;
        tick();
        cmdIf.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tickN(2);
        compared++;
        if (motorCikis !== 4'b0000 || cmdIf.cmd_ready !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: coil=%b ready=%b busy=%b, want 0000 0 0",
                     motorCikis, cmdIf.cmd_ready, busy);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (motorCikis !== 4'b0001 || cmdIf.cmd_ready !== 1'b1 || busy !== 1'b0 ||
            phase_idx !== 3'd0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_exit: coil=%b ready=%b busy=%b idx=%0d done=%b, want 0001 1 0 0 0",
                     motorCikis, cmdIf.cmd_ready, busy, phase_idx, done);
        end
    endtask

    task automatic test_forward();
        expIdx = 3'd0;
        accept(1'b1, 10, 1000);
        compared++;
        if (busy !== 1'b1 || cmdIf.cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL fwd_start: busy=%b ready=%b, want 1 0", busy, cmdIf.cmd_ready);
        end
        for (int s = 1; s <= 10; s++) begin
            tickN(999);
            compared++;
            if (phase_idx !== expIdx || done !== 1'b0) begin
                mismatched++;
                $display("FAIL fwd_early step %0d: idx=%0d done=%b, want %0d 0",
                         s, phase_idx, done, expIdx);
            end
            tick();
            expIdx = expIdx + 3'd1;
            compared++;
            if (phase_idx !== expIdx || motorCikis !== tbl(expIdx)) begin
                mismatched++;
                $display("FAIL fwd_step %0d: idx=%0d coil=%b, want %0d %b",
                         s, phase_idx, motorCikis, expIdx, tbl(expIdx));
            end
        end
        compared++;
        if (done !== 1'b1 || aborted !== 1'b0 || busy !== 1'b0 || phase_idx !== 3'd2) begin
            mismatched++;
            $display("FAIL fwd_done: done=%b aborted=%b busy=%b idx=%0d, want 1 0 0 2",
                     done, aborted, busy, phase_idx);
        end
        tick();
        compared++;
        if (done !== 1'b0 || cmdIf.cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL fwd_idle: done=%b ready=%b, want 0 1", done, cmdIf.cmd_ready);
        end
    endtask

    task automatic test_reverse_clamped();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        expIdx = 3'd0;
        accept(1'b0, 3, 5);
        for (int s = 1; s <= 3; s++) begin
            tickN(999);
            compared++;
            if (phase_idx !== expIdx) begin
                mismatched++;
                $display("FAIL rev_early step %0d: idx=%0d, want %0d", s, phase_idx, expIdx);
            end
            tick();
            expIdx = expIdx - 3'd1;
            compared++;
            if (phase_idx !== expIdx || motorCikis !== tbl(expIdx)) begin
                mismatched++;
                $display("FAIL rev_step %0d: idx=%0d coil=%b, want %0d %b",
                         s, phase_idx, motorCikis, expIdx, tbl(expIdx));
            end
        end
        compared++;
        if (done !== 1'b1 || phase_idx !== 3'd5 || motorCikis !== 4'b1100) begin
            mismatched++;
            $display("FAIL rev_done: done=%b idx=%0d coil=%b, want 1 5 1100",
                     done, phase_idx, motorCikis);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cmdIf.cmd_dir    = 1'b1;
        cmdIf.cmd_steps  = '0;
        cmdIf.cmd_period = PER_W'(1000);
        cmdIf.cmd_valid  = 1'b1;
        tick();
        cmdIf.cmd_steps  = CNT_W'(1);
        compared++;
        if (done !== 1'b1 || busy !== 1'b0 || cmdIf.cmd_ready !== 1'b0 ||
            motorCikis !== 4'b1100) begin
            mismatched++;
            $display("FAIL zero_done: done=%b busy=%b ready=%b coil=%b, want 1 0 0 1100",
                     done, busy, cmdIf.cmd_ready, motorCikis);
        end
        tick();
        compared++;
        if (done !== 1'b0 || busy !== 1'b0 || cmdIf.cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_idle: done=%b busy=%b ready=%b, want 0 0 1",
                     done, busy, cmdIf.cmd_ready);
        end
        tick();
        cmdIf.cmd_valid = 1'b0;
        compared++;
        if (busy !== 1'b1 || cmdIf.cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_accept: busy=%b ready=%b, want 1 0", busy, cmdIf.cmd_ready);
        end
        tickN(1000);
        compared++;
        if (phase_idx !== 3'd6 || motorCikis !== 4'b1000 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_step: idx=%0d coil=%b done=%b, want 6 1000 1",
                     phase_idx, motorCikis, done);
        end
        tick();
    endtask

    task automatic test_abort();
        expIdx = 3'd6;
        accept(1'b1, 100, 1000);
        for (int s = 1; s <= 3; s++) begin
            tickN(1000);
            expIdx = expIdx + 3'd1;
            compared++;
            if (phase_idx !== expIdx) begin
                mismatched++;
                $display("FAIL abort_pre step %0d: idx=%0d, want %0d", s, phase_idx, expIdx);
            end
        end
        tickN(999);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        compared++;
        if (done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0 ||
            phase_idx !== 3'd1 || motorCikis !== 4'b0011) begin
            mismatched++;
            $display("FAIL abort_end: done=%b aborted=%b busy=%b idx=%0d coil=%b, want 1 1 0 1 0011",
                     done, aborted, busy, phase_idx, motorCikis);
        end
        tick();
        compared++;
        if (done !== 1'b0 || aborted !== 1'b0 || cmdIf.cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_pulse: done=%b aborted=%b ready=%b, want 0 0 1",
                     done, aborted, cmdIf.cmd_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        compared++;
        if (done !== 1'b0 || aborted !== 1'b0 || cmdIf.cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_idle: done=%b aborted=%b ready=%b, want 0 0 1",
                     done, aborted, cmdIf.cmd_ready);
        end
    endtask

    task automatic test_release();
        release_en = 1'b1;
        tick();
        compared++;
        if (motorCikis !== 4'b0000 || phase_idx !== 3'd1) begin
            mismatched++;
            $display("FAIL release_on: coil=%b idx=%0d, want 0000 1", motorCikis, phase_idx);
        end
        release_en = 1'b0;
        tick();
        compared++;
        if (motorCikis !== 4'b0011) begin
            mismatched++;
            $display("FAIL release_off: coil=%b, want 0011", motorCikis);
        end
    endtask

    task automatic test_rst_mid_move();
        accept(1'b1, 5, 1000);
        tickN(1500);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (motorCikis !== 4'b0000 || busy !== 1'b0 || phase_idx !== 3'd0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid: coil=%b busy=%b idx=%0d done=%b, want 0000 0 0 0",
                     motorCikis, busy, phase_idx, done);
        end
        tick();
        rst = 1'b0;
        compared++;
        if (done !== 1'b0 || motorCikis !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_hold: done=%b coil=%b, want 0 0000", done, motorCikis);
        end
        tick();
        compared++;
        if (motorCikis !== 4'b0001 || cmdIf.cmd_ready !== 1'b1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_exit: coil=%b ready=%b done=%b, want 0001 1 0",
                     motorCikis, cmdIf.cmd_ready, done);
        end
        accept(1'b1, 1, 1000);
        tickN(1000);
        compared++;
        if (phase_idx !== 3'd1 || motorCikis !== 4'b0011 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_restart: idx=%0d coil=%b done=%b, want 1 0011 1",
                     phase_idx, motorCikis, done);
        end
        tick();
    endtask

    initial begin
        cmdIf.cmd_valid  = 1'b0;
        cmdIf.cmd_dir    = 1'b0;
        cmdIf.cmd_steps  = '0;
        cmdIf.cmd_period = '0;
        test_reset();
        test_forward();
        test_reverse_clamped();
        test_back_to_back();
        test_abort();
        test_release();
        test_rst_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
